// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl - central pipeline control for the six-stage MIPS core
//
// Merges stall requests from id/ex/mem into a per-stage hold vector, turns
// exception / eret commits into a one-cycle flush plus redirect PC, blanks
// further requests while the squashed stages drain, and flags a pipeline
// that has been stalled for too long.
//
// Parameters:
//   SQUASH_CYCLES  cycles after a flush during which requests are ignored (1..15)
//   STALL_TIMEOUT  consecutive stalled cycles that set stall_timeout (>= 2)
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous active-high reset
//   stallreq_id    id stage stall request (load-use hazard)
//   stallreq_ex    ex stage stall request (multi-cycle madd/div)
//   stallreq_mem   mem stage stall request (bus wait)
//   except_req     committed exception from mem
//   except_vec     handler address for except_req
//   eret_req       committed eret from mem
//   epc            return address for eret_req
//   stall[5:0]     per-stage hold, bit0 = pc ... bit5 = wb
//   flush          clear all pipeline registers this cycle
//   new_pc         redirect target, valid only while flush = 1 (0 otherwise)
//   stall_timeout  sticky watchdog flag, cleared only by rst
//
// Optional build macro PIPE_CTRL_PERF_EN adds:
//   perf_stall_cycles[31:0]  cycles with stall != 0 (wraps)
//   perf_flush_count[15:0]   flush cycles (saturates at 16'hFFFF)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int SQUASH_CYCLES = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_req,
  input  logic [31:0] except_vec,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_count
`endif
);

  localparam int              WD_W    = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STALL_TIMEOUT);
  localparam logic [3:0]      SQ_LOAD = 4'(SQUASH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      sq_cnt, sq_cnt_nxt;
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic [5:0]      stall_req;

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + WD_W'(1);
  endfunction

  // The latest requesting stage wins: holding a later stage implies holding
  // every earlier one.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_ex) stall_req = 6'b001111;
    else if (stallreq_id) stall_req = 6'b000111;
  end

  always_comb begin
    state_nxt  = state;
    sq_cnt_nxt = sq_cnt;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0000_0000;
    case (state)
      RUN, STALL: begin
        if (except_req || eret_req) begin
          // Redirect overrides any stall request in the same cycle.
          flush      = 1'b1;
          new_pc     = except_req ? except_vec : epc;
          state_nxt  = SQUASH;
          sq_cnt_nxt = SQ_LOAD;
        end else begin
          stall     = stall_req;
          state_nxt = (stall_req != 6'b000000) ? STALL : RUN;
        end
      end
      SQUASH: begin
        // Requests from squashed bubbles are ignored until the window ends.
        if (sq_cnt == 4'd0) state_nxt = RUN;
        else                sq_cnt_nxt = sq_cnt - 4'd1;
      end
      default: state_nxt = RUN;
    endcase
    // Outputs are quiet for the whole reset pulse, not just after the edge.
    if (rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'h0000_0000;
    end
  end

  assign wd_cnt_nxt = ((stall != 6'b000000) && !flush) ? wd_sat_inc(wd_cnt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      sq_cnt        <= 4'd0;
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      sq_cnt <= sq_cnt_nxt;
      wd_cnt <= wd_cnt_nxt;
      if (wd_cnt_nxt == WD_MAX) stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_count  <= 16'd0;
    end else begin
      if (stall != 6'b000000) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush)              perf_flush_count  <= sat_inc16(perf_flush_count);
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl - directed, table-driven bench for pipe_ctrl
// (SQUASH_CYCLES = 2, STALL_TIMEOUT = 8). Each table row is one clock cycle:
// inputs are driven just after the rising edge and outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        except_req, eret_req;
  logic [31:0] except_vec, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.SQUASH_CYCLES(2), .STALL_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .except_req   (except_req),
    .except_vec   (except_vec),
    .eret_req     (eret_req),
    .epc          (epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count (perf_flush_count)
`endif
  );

  typedef struct {
    logic        id, ex, mem, exc, eret;
    logic [31:0] vec, pc_in;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic id, ex, mem, exc, eret,
                              input logic [31:0] vec, pc_in,
                              input logic [5:0] e_stall, input logic e_flush,
                              input logic [31:0] e_pc, input logic e_to);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.eret = eret;
    v.vec = vec; v.pc_in = pc_in;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc; v.e_to = e_to;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic id, ex, mem, exc, eret, input logic [31:0] vec, pc_in);
    stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    except_req = exc; eret_req = eret; except_vec = vec; epc = pc_in;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);

    // ---- Table ----
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0); // reset state
    add(1,0,0,0,0, 32'h0,   32'h0,    6'b000111, 0, 32'h0,    0);
    add(1,1,0,0,0, 32'h0,   32'h0,    6'b001111, 0, 32'h0,    0);
    add(1,1,1,0,0, 32'h0,   32'h0,    6'b011111, 0, 32'h0,    0);
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    add(0,0,1,1,0, 32'h40,  32'h0,    6'b000000, 1, 32'h40,   0); // exception over mem stall
    add(0,0,1,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0); // squash 1
    add(0,0,1,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0); // squash 2
    add(0,0,1,0,0, 32'h0,   32'h0,    6'b011111, 0, 32'h0,    0); // back in RUN
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    add(0,0,0,1,1, 32'h80,  32'h1000, 6'b000000, 1, 32'h80,   0); // except beats eret
    add(0,0,0,1,0, 32'h100, 32'h0,    6'b000000, 0, 32'h0,    0); // blanked
    add(0,0,0,1,0, 32'h100, 32'h0,    6'b000000, 0, 32'h0,    0); // blanked
    add(0,0,0,1,0, 32'h100, 32'h0,    6'b000000, 1, 32'h100,  0); // flush at +3
    add(0,0,0,0,1, 32'h0,   32'h2000, 6'b000000, 0, 32'h0,    0); // eret ignored in squash
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    add(0,0,0,0,1, 32'h0,   32'h1000, 6'b000000, 1, 32'h1000, 0); // eret alone
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    add(1,0,0,0,0, 32'h0,   32'h0,    6'b000111, 0, 32'h0,    0); // enter STALL
    add(1,1,1,1,1, 32'h200, 32'h1000, 6'b000000, 1, 32'h200,  0); // everything at once
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    for (int i = 0; i < 7; i++)
      add(0,1,0,0,0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0);       // 7 stalls: no timeout
    add(0,0,0,0,0, 32'h0,   32'h0,    6'b000000, 0, 32'h0,    0);
    for (int i = 0; i < 8; i++)
      add(0,1,0,0,0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 0);       // 8 stalls
    for (int i = 0; i < 3; i++)
      add(0,0,0,0,0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 1);       // sticky flag

    // Outputs forced low during reset even with active requests.
    #2;
    drive(0, 0, 1, 1, 0, 32'h40, 32'h0);
    #1;
    chk("rst_stall", 0, 32'(stall), 32'h0);
    chk("rst_flush", 0, 32'(flush), 32'h0);
    chk("rst_newpc", 0, new_pc, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].exc, vecs[i].eret, vecs[i].vec, vecs[i].pc_in);
      @(negedge clk);
      chk("stall",   i, 32'(stall),         32'(vecs[i].e_stall));
      chk("flush",   i, 32'(flush),         32'(vecs[i].e_flush));
      chk("new_pc",  i, new_pc,             vecs[i].e_pc);
      chk("timeout", i, 32'(stall_timeout), 32'(vecs[i].e_to));
      next_cycle();
    end

    // ---- rst pulse clears the sticky watchdog flag ----
    rst = 1'b1;
    #1;
    chk("timeout_rst", 0, 32'(stall_timeout), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("timeout_after_rst", 0, 32'(stall_timeout), 32'h0);
    next_cycle();

    // ---- 5 stalled cycles, then two flushes separated by the squash window ----
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      chk("perf_seq_stall", i, 32'(stall), 32'h07);
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("perf_seq_flush", 0, 32'(flush), 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) next_cycle();
    drive(0, 0, 0, 1, 0, 32'h44, 32'h0);
    @(negedge clk);
    chk("perf_seq_flush", 1, 32'(flush), 32'h1);
    chk("perf_seq_pc", 1, new_pc, 32'h44);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) next_cycle();
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_cycles", 0, perf_stall_cycles, 32'd5);
    chk("perf_flush_count", 0, 32'(perf_flush_count), 32'd2);
`endif

    // ---- async reset mid-squash, then eret in the first cycle after release ----
    drive(0, 0, 0, 1, 0, 32'h80, 32'h0);
    @(negedge clk);
    chk("sq_flush", 0, 32'(flush), 32'h1);
    next_cycle();                           // now in SQUASH
    drive(0, 0, 1, 1, 0, 32'h80, 32'h0);
    #1;
    chk("sq_stall", 0, 32'(stall), 32'h0);
    chk("sq_flush", 1, 32'(flush), 32'h0);
    rst = 1'b1;                             // between clock edges
    #1;
    chk("async_stall", 0, 32'(stall), 32'h0);
    chk("async_flush", 0, 32'(flush), 32'h0);
    chk("async_newpc", 0, new_pc, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0, 32'hBFC0_0000);
    #1;
    chk("async_newpc", 1, new_pc, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_flush", 0, 32'(flush), 32'h1);
    chk("post_rst_newpc", 0, new_pc, 32'hBFC0_0000);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_flush", 1, 32'(flush), 32'h0);
    chk("post_rst_newpc", 1, new_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
